fifo_enq_arb: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_enq_arb_rr_pick.sv | 38 +++
 rtl/fifo_enq_arb.sv | 128 ++++++++++++
 tb/tb_fifo_enq_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo enqueue arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbitration state enum, packet counter width.
package fifo_arb_pkg;

  // IDLE: grant is free to move to the next round-robin winner.
  // LOCK: grant is held by one requester until its last beat is accepted.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_st_t;

  localparam int PKT_CNT_WIDTH = 16;

endpackage

// File: rtl/fifo_enq_arb_rr_pick.sv
// Round-robin priority picker: first set bit of vld at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only selects, the caller owns flow control.
//
// Ports:
//   vld     [N-1:0]     candidate request vector
//   ptr     [ID_W-1:0]  highest-priority index this cycle (must be < N)
//   any_vld             at least one candidate is set
//   win_idx [ID_W-1:0]  winning index; 0 when nothing is set
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    vld,
  input  logic [ID_W-1:0] ptr,
  output logic            any_vld,
  output logic [ID_W-1:0] win_idx
);

  // Scan offsets from farthest to nearest so the nearest set bit after
  // ptr is the last assignment and therefore wins. N need not be a power
  // of two, so the wrap is an explicit compare rather than a bit mask.
  always_comb begin
    int          idx;
    logic [ID_W-1:0] idx_l;
    idx     = 0;
    idx_l   = '0;
    any_vld = |vld;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_l = ID_W'(idx);
      if (vld[idx_l]) win_idx = idx_l;
    end
  end

endmodule

// File: rtl/fifo_enq_arb.sv
// Round-robin arbiter sharing one fifo enqueue port among N_REQ requesters, packet-locked.
// Latency: zero cycles, outputs are combinational from inputs and arbitration state.
// Backpressure: enq_ready low stalls the selected requester and freezes the grant.
//
// Optional build macro: FIFO_ENQ_ARB_STATS_EN adds per-requester packet counters (pkt_cnt).
// Ports:
//   clk, rst_aL                 clock, async active-low reset
//   req_valid/req_last [N_REQ]  per-requester beat valid and last-beat flag
//   req_data [N_REQ][W]         per-requester beat data
//   req_ready [N_REQ]           one-hot (or zero) accept to the selected requester
//   enq_valid/enq_data/enq_ready  fifo enqueue handshake
//   grant_id                    current winner/owner, meaningful when enq_valid=1
//   pkt_cnt [N_REQ][16]         completed packets per requester (stats build only)
module fifo_enq_arb
  import fifo_arb_pkg::*;
#(
  parameter  int ENTRY_WIDTH = 32,
  parameter  int N_REQ       = 4,
  localparam int ID_WIDTH    = $clog2(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_aL,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0]                    req_last,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                    req_ready,
  output logic                                enq_valid,
  output logic [ENTRY_WIDTH-1:0]              enq_data,
  input  logic                                enq_ready,
`ifdef FIFO_ENQ_ARB_STATS_EN
  output logic [N_REQ-1:0][PKT_CNT_WIDTH-1:0] pkt_cnt,
`endif
  output logic [ID_WIDTH-1:0]                 grant_id
);

  arb_st_t             st_q, st_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  logic                any_vld;
  logic [ID_WIDTH-1:0] win_idx;
  logic [ID_WIDTH-1:0] sel;
  logic [ID_WIDTH-1:0] sel_inc;
  logic                xfer;
  logic                pkt_end;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_WIDTH)
  ) u_rr_pick (
    .vld     (req_valid),
    .ptr     (ptr_q),
    .any_vld (any_vld),
    .win_idx (win_idx)
  );

  // While locked the owner keeps the port even if it drops valid, so no
  // other requester can interleave beats into its packet.
  always_comb begin
    sel       = (st_q == ARB_LOCK) ? owner_q : win_idx;
    enq_valid = (st_q == ARB_LOCK) ? req_valid[owner_q] : any_vld;
    enq_data  = req_data[sel];
    grant_id  = sel;
    xfer      = enq_valid & enq_ready;
    pkt_end   = xfer & req_last[sel];
    sel_inc   = (sel == ID_WIDTH'(N_REQ - 1)) ? '0 : sel + 1'b1;
    req_ready      = '0;
    req_ready[sel] = xfer;
  end

  // A valid beat that is not accepted in IDLE also locks: the stalled beat
  // must be the one that goes next, whatever else becomes valid meanwhile.
  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (st_q == ARB_IDLE) begin
      if (enq_valid) begin
        if (pkt_end) begin
          ptr_d = sel_inc;
        end else begin
          st_d    = ARB_LOCK;
          owner_d = sel;
        end
      end
    end else begin
      if (pkt_end) begin
        st_d  = ARB_IDLE;
        ptr_d = sel_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      st_q    <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef FIFO_ENQ_ARB_STATS_EN
  logic [N_REQ-1:0][PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  // Saturating: a wrapped counter would read as few packets, not many.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_end && (pkt_cnt_q[sel] != {PKT_CNT_WIDTH{1'b1}})) begin
      pkt_cnt_d[sel] = pkt_cnt_q[sel] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_enq_arb.sv
// Bench for fifo_enq_arb: directed packet scenarios against a packet-level model.
// Latency: expects zero-cycle combinational outputs.
// Backpressure: drives enq_ready low to exercise stalls and grant freezing.
module tb_fifo_enq_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst_aL;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_last;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                enq_valid;
  logic [W-1:0]        enq_data;
  logic                enq_ready;
  logic [1:0]          grant_id;
`ifdef FIFO_ENQ_ARB_STATS_EN
  logic [N-1:0][15:0]  pkt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_enq_arb #(.ENTRY_WIDTH(W), .N_REQ(N)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
`ifdef FIFO_ENQ_ARB_STATS_EN
    .pkt_cnt   (pkt_cnt),
`endif
    .grant_id  (grant_id)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- requester driver ----------------
  int bl[N];        // beats left in current packet
  int pq[N][$];     // queued packet lengths
  bit pause[N];     // owner temporarily drops valid between beats
  int seq[N];       // beat sequence number, becomes the data payload

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (bl[i] > 0) && !pause[i];
      req_last[i]  = (bl[i] == 1);
      req_data[i]  = {i[7:0], seq[i][23:0]};
    end
  endfunction

  task automatic load(input int r, input int len);
    if (bl[r] == 0) bl[r] = len;
    else pq[r].push_back(len);
  endtask

  // One clock: literal checks at the negedge, then advance requesters that
  // were accepted at the posedge.
  task automatic cyc(input bit c, input bit ev, input int gid, input logic [N-1:0] rdy,
                     input string nm);
    logic [N-1:0] acc;
    bit           live;
    @(negedge clk);
    if (c) begin
      chk({nm, "_vld"}, enq_valid, ev);
      chk({nm, "_rdy"}, req_ready, rdy);
      if (ev) chk({nm, "_gid"}, grant_id, gid);
    end
    acc  = req_ready;
    live = rst_aL;
    @(posedge clk);
    #1;
    if (live) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          seq[i]++;
          bl[i]--;
          if (bl[i] == 0 && pq[i].size() > 0) bl[i] = pq[i].pop_front();
        end
      end
    end
    drive();
  endtask

  // ---------------- packet-level model + protocol check ----------------
  bit           m_lock;   // some requester owns the port mid-packet
  int           m_own;
  int           m_ptr;    // where the round-robin search starts
  int           m_cnt[N];
  bit           prev_rst = 1'b0;
  logic [N-1:0] prev_pend = '0;
  logic [N-1:0] prev_last;
  logic [N-1:0][W-1:0] prev_data;

  always @(negedge clk) begin
    int           sel;
    bit           ev;
    logic [N-1:0] er;
    if (!rst_aL) begin
      m_lock = 1'b0;
      m_own  = 0;
      m_ptr  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
    sel = -1;
    if (m_lock) sel = m_own;
    else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (sel < 0 && req_valid[j]) sel = j;
      end
    end
    ev = 1'b0;
    if (sel >= 0) ev = req_valid[sel];
    er = '0;
    if (ev && enq_ready) er[sel] = 1'b1;
    chk("m_enq_valid", enq_valid, ev);
    chk("m_req_ready", req_ready, er);
    if (ev) begin
      chk("m_grant_id", grant_id, sel);
      chk("m_enq_data", enq_data, req_data[sel]);
    end
`ifdef FIFO_ENQ_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("m_pkt_cnt", pkt_cnt[i], m_cnt[i]);
`endif
    if (rst_aL && ev) begin
      if (enq_ready && req_last[sel]) begin
        m_lock = 1'b0;
        m_ptr  = (sel + 1) % N;
        if (m_cnt[sel] < 65535) m_cnt[sel]++;
      end else begin
        m_lock = 1'b1;
        m_own  = sel;
      end
    end
    // Requesters must hold valid/data/last until accepted.
    if (rst_aL && prev_rst) begin
      for (int i = 0; i < N; i++) begin
        if (prev_pend[i]) begin
          chk("proto_hold", {req_valid[i], req_last[i], req_data[i]},
              {1'b1, prev_last[i], prev_data[i]});
        end
      end
    end
    prev_pend = req_valid & ~req_ready;
    prev_last = req_last;
    prev_data = req_data;
    prev_rst  = rst_aL;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst_aL    = 1'b0;
    enq_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bl[i] = 0; pause[i] = 1'b0; seq[i] = 0;
    end
    seq[0] = 32'h0000_AB12;
    drive();

    // Reset, nothing valid.
    @(negedge clk);
    chk("rst_vld",  enq_valid, 1'b0);
    chk("rst_rdy",  req_ready, 4'b0000);
    chk("rst_gid",  grant_id,  2'd0);
    chk("rst_data", enq_data,  32'h0000_AB12);
`ifdef FIFO_ENQ_ARB_STATS_EN
    chk("rst_cnt",  pkt_cnt,   64'd0);
`endif
    @(posedge clk);
    #1;
    rst_aL    = 1'b1;
    enq_ready = 1'b1;

    // All four valid with single-beat packets: plain rotation.
    for (int i = 0; i < N; i++) begin
      load(i, 1);
      load(i, 1);
    end
    drive();
    for (int c = 0; c < 8; c++) cyc(1, 1, c % 4, N'(1 << (c % 4)), "rr");

    // Move ptr to 2, then a 3-beat packet from req 2 against a waiting req 0.
    load(1, 1); drive();
    cyc(1, 1, 1, 4'b0010, "warm1");
    load(2, 3); load(0, 1); drive();
    for (int b = 0; b < 3; b++) cyc(1, 1, 2, 4'b0100, "pkt3");
    cyc(1, 1, 0, 4'b0001, "after_pkt3");
    load(3, 1); drive();
    cyc(1, 1, 3, 4'b1000, "warm3");   // ptr now 0

    // Stall with only req 1 valid; req 0 arriving later must not steal it.
    enq_ready = 1'b0;
    load(1, 1); drive();
    for (int s = 0; s < 5; s++) cyc(1, 1, 1, 4'b0000, "stall");
    load(0, 1); enq_ready = 1'b1; drive();
    cyc(1, 1, 1, 4'b0010, "frozen");
    cyc(1, 1, 0, 4'b0001, "next0");

    // Req 3 pauses mid-packet while req 1 waits.
    load(3, 4); drive();
    cyc(1, 1, 3, 4'b1000, "r3_b1");
    pause[3] = 1'b1; load(1, 1); drive();
    for (int p = 0; p < 2; p++) cyc(1, 0, 0, 4'b0000, "pause");
    pause[3] = 1'b0; drive();
    for (int b = 0; b < 3; b++) cyc(1, 1, 3, 4'b1000, "r3_res");
    cyc(1, 1, 1, 4'b0010, "r1_after");  // ptr now 2

    // Reset in the middle of a req 1 packet.
    load(1, 3); drive();
    cyc(1, 1, 1, 4'b0010, "r1_b1");
    load(2, 1); load(0, 1);
    rst_aL = 1'b0; enq_ready = 1'b0; drive();
    cyc(1, 1, 0, 4'b0000, "in_rst");
`ifdef FIFO_ENQ_ARB_STATS_EN
    chk("rst2_cnt", pkt_cnt, 64'd0);
`endif
    bl[1] = 0; pq[1].delete(); drive();   // truncated packet is abandoned
    cyc(1, 1, 0, 4'b0000, "in_rst2");
    rst_aL = 1'b1; enq_ready = 1'b1; drive();
    cyc(1, 1, 0, 4'b0001, "post_rst0");
    cyc(1, 1, 2, 4'b0100, "post_rst2");

    // Two more req 2 packets: three since reset.
    load(2, 1); load(2, 1); drive();
    cyc(1, 1, 2, 4'b0100, "s2a");
    cyc(1, 1, 2, 4'b0100, "s2b");
    @(negedge clk);
`ifdef FIFO_ENQ_ARB_STATS_EN
    chk("cnt2", pkt_cnt[2], 16'd3);
`endif
    chk("idle_vld", enq_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
